pipelined_memory: RTL and testbench
===================================

# pipelined_memory

Parametrised, handshaked, single-port data/instruction memory for the 16-bit RISC core; next generation of the flat MEMORY block. Adds configurable width and depth, byte-enable writes, a configurable read-latency pipeline with a valid flag, and a post-reset hardware clear sequence. Sits between the datapath/fetch stage and the word array; ProgramCounter output or ALU address drives REQ_ADDR.

## Interface

- DATA_W, 16: word width in bits; must be a multiple of 8.
- ADDR_W, 16: request address width (word addressing).
- DEPTH_LOG2, 8: array holds 2^DEPTH_LOG2 words.
- RD_LAT, 2: read latency in cycles, legal 1..4.
- CLEAR_ON_RST, 1: 1 = zero the whole array after reset; 0 = skip clear.

- CLOCK  in  1  sole clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-low.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block accepts a request this cycle.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  ADDR_W  word address.
- REQ_WDATA  in  DATA_W  write data.
- REQ_BE  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
- RD_VALID  out  1  RD_DATA holds a read result this cycle.
- RD_DATA  out  DATA_W  read result.
- CLEAR_BUSY  out  1  clear sequence in progress.

## Operation

- FSM states: CLEAR, READY.
- RST=0 at an edge: state <- CLEAR, clear counter <- 0, all pipeline valid bits <- 0, RD_DATA <- 0. Array contents untouched by reset itself.
- CLEAR (RST=1): writes 0 to word [counter], counter +1 per cycle; after word 2^DEPTH_LOG2-1 is written, state <- READY. CLEAR_BUSY=1 throughout. With CLEAR_ON_RST=0, CLEAR lasts exactly one cycle and writes nothing.
- REQ_READY = (state==READY) & RST. Handshake completes when REQ_VALID & REQ_READY at an edge; otherwise request ignored, no side effects.
- Index = REQ_ADDR[DEPTH_LOG2-1:0]; upper bits ignored (aliasing, no error).
- Write: bytes with REQ_BE[i]=1 updated at accepting edge; others keep value. REQ_BE=0 is a legal no-op write. No RD_VALID for writes.
- Read: array word sampled at accepting edge, shifted through RD_LAT-1 further register stages with a valid bit.
- RD_DATA holds last delivered value while RD_VALID=0.
- One request per cycle, fully pipelined; no back-pressure on the read output.

## Timing

- Reset values: REQ_READY=0, RD_VALID=0, RD_DATA=0, CLEAR_BUSY=1 (state CLEAR).
- Clear duration: 2^DEPTH_LOG2 cycles after first edge with RST=1; REQ_READY rises the cycle after the final clear write.
- Read accepted at edge k: RD_VALID=1 and RD_DATA valid after edge k+RD_LAT-1, for exactly one cycle per accepted read.
- Write accepted at edge k, read of same index accepted at edge k+1: returns new data (no stale hazard). Single port, so read and write never coincide.
- RST=0 mid-operation: in-flight reads discarded (RD_VALID=0 after that edge), any request in that cycle not performed, clear restarts from word 0.
- RST=0 during CLEAR: counter restarts at 0.

## Test plan

- Reset then release, DEPTH_LOG2=4: CLEAR_BUSY=1 for 16 cycles, REQ_READY=0 throughout, then REQ_READY=1; reads of all 16 words return 0x0000.
- Write 0xBEEF to addr 0x0003 BE=2'b11, write 0x12xx to addr 0x0003 BE=2'b10 with data 0x1234: read returns 0x12EF after exactly RD_LAT cycles with single-cycle RD_VALID.
- Back-to-back reads of addrs 0,1,2,3 (preloaded 0xA000..0xA003), RD_LAT=3: RD_VALID high 4 consecutive cycles, data in order, first at edge k+2.
- Aliasing, DEPTH_LOG2=4: write 0x5555 to 0x0012; read 0x0002 returns 0x5555.
- Reads issued at edges k, k+1 then RST=0 at k+1 with RD_LAT=4: no RD_VALID pulses appear; clear restarts; REQ_VALID ignored during CLEAR.
- CLEAR_ON_RST=0: prior contents survive reset; REQ_READY=1 one cycle after RST release.

Source files
------------

// File: rtl/pipelined_memory.sv
`default_nettype none
// ============================================================================
// pipelined_memory : handshaked single-port word memory with byte enables,
//                    configurable read latency and post-reset array clear.
// Revision: 1.0
// ============================================================================
module pipelined_memory #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int DEPTH_LOG2   = 8,
  parameter int RD_LAT       = 2,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                clear_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [DEPTH_LOG2-1:0]   clr_cnt;
  logic                    clr_last;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    acc_rd;
  logic                    acc_wr;
  logic                    tail_valid;
  logic [DATA_W-1:0]       tail_data;

  assign idx        = req_addr[DEPTH_LOG2-1:0];
  assign req_ready  = (state == ST_READY) & rst;
  assign clear_busy = (state == ST_CLEAR);
  assign acc_rd     = req_valid & req_ready & ~req_we;
  assign acc_wr     = req_valid & req_ready & req_we;

  // Without a clear the CLEAR state is a single pass-through cycle.
  assign clr_last = (CLEAR_ON_RST == 0) ? 1'b1 : (clr_cnt == {DEPTH_LOG2{1'b1}});

  generate
    if (ADDR_W > DEPTH_LOG2) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr[ADDR_W-1:DEPTH_LOG2];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (clr_last) state_next = ST_READY;
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst && (state == ST_CLEAR) && (CLEAR_ON_RST != 0)) begin
      mem[clr_cnt] <= '0;
    end else if (acc_wr) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_be[b]) begin
          mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Stages ahead of the output register; the output register is the last stage.
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign tail_valid = acc_rd;
      assign tail_data  = mem[idx];
    end else begin : g_latn
      logic [RD_LAT-2:0] mid_valid;
      logic [DATA_W-1:0] mid_data [RD_LAT-1];

      always_ff @(posedge clock) begin
        if (!rst) begin
          mid_valid <= '0;
        end else begin
          mid_valid[0] <= acc_rd;
          for (int i = 1; i < RD_LAT-1; i++) begin
            mid_valid[i] <= mid_valid[i-1];
          end
        end
      end

      always_ff @(posedge clock) begin
        if (acc_rd) begin
          mid_data[0] <= mem[idx];
        end
        for (int i = 1; i < RD_LAT-1; i++) begin
          mid_data[i] <= mid_data[i-1];
        end
      end

      assign tail_valid = mid_valid[RD_LAT-2];
      assign tail_data  = mid_data[RD_LAT-2];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= tail_valid;
      if (tail_valid) begin
        rd_data <= tail_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_memory.sv
`default_nettype none
// ============================================================================
// tb_pipelined_memory : three pipelined_memory units (RD_LAT 1/3/4, clear on/off)
// Revision: 1.0
// ============================================================================
module tb_pipelined_memory;

  localparam int NU   = 3;
  localparam int ECAP = 4096;

  logic        clk;
  logic        rst        [NU];
  logic        req_valid  [NU];
  logic        req_ready  [NU];
  logic        req_we     [NU];
  logic [15:0] req_addr   [NU];
  logic [15:0] req_wdata  [NU];
  logic [1:0]  req_be     [NU];
  logic        rd_valid   [NU];
  logic [15:0] rd_data    [NU];
  logic        clear_busy [NU];

  int total;
  int bad;
  int ecnt;

  // Reference model state, one set per unit.
  logic [15:0] mdl   [NU][16];
  logic        ev    [NU][ECAP];
  logic [15:0] ed    [NU][ECAP];
  logic        mready[NU];
  int          mclr  [NU];
  logic [15:0] last  [NU];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NU; g++) begin : g_dut
      pipelined_memory #(
        .DATA_W      (16),
        .ADDR_W      (16),
        .DEPTH_LOG2  (4),
        .RD_LAT      ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
        .CLEAR_ON_RST((g == 2) ? 0 : 1)
      ) dut (
        .clock     (clk),
        .rst       (rst[g]),
        .req_valid (req_valid[g]),
        .req_ready (req_ready[g]),
        .req_we    (req_we[g]),
        .req_addr  (req_addr[g]),
        .req_wdata (req_wdata[g]),
        .req_be    (req_be[g]),
        .rd_valid  (rd_valid[g]),
        .rd_data   (rd_data[g]),
        .clear_busy(clear_busy[g])
      );
    end
  endgenerate

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic logic clr_of(input int k);
    return (k != 2);
  endfunction

  function automatic int clen_of(input int k);
    return clr_of(k) ? 16 : 1;
  endfunction

  // Drive one cycle of unit u, advance the model of every unit by one edge,
  // and return at the following falling edge.
  task automatic step(input int u, input logic r, input logic v, input logic we,
                      input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    logic [3:0] idx;
    rst[u]       = r;
    req_valid[u] = v;
    req_we[u]    = we;
    req_addr[u]  = a;
    req_wdata[u] = d;
    req_be[u]    = be;
    for (int k = 0; k < NU; k++) begin
      if (!rst[k]) begin
        mready[k] = 1'b0;
        mclr[k]   = clen_of(k);
        last[k]   = 16'h0000;
        for (int t = ecnt + 1; t < ecnt + 8; t++) ev[k][t] = 1'b0;
      end else if (!mready[k]) begin
        mclr[k] = mclr[k] - 1;
        if (mclr[k] == 0) begin
          mready[k] = 1'b1;
          if (clr_of(k)) for (int i = 0; i < 16; i++) mdl[k][i] = 16'h0000;
        end
      end else if (k == u && v) begin
        idx = a[3:0];
        if (we) begin
          for (int b = 0; b < 2; b++) if (be[b]) mdl[k][idx][8*b +: 8] = d[8*b +: 8];
        end else begin
          ev[k][ecnt + lat_of(k)] = 1'b1;
          ed[k][ecnt + lat_of(k)] = mdl[k][idx];
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    ecnt = ecnt + 1;
    req_valid[u] = 1'b0;
    for (int k = 0; k < NU; k++) if (ev[k][ecnt]) last[k] = ed[k][ecnt];
  endtask

  task automatic test_reset(input int u);
    step(u, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    step(u, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 2'b11);
    total++; if (req_ready[u] !== 1'b0) begin bad++; $display("FAIL reset_ready u=%0d got=%b exp=0", u, req_ready[u]); end
    total++; if (rd_valid[u] !== 1'b0) begin bad++; $display("FAIL reset_rd_valid u=%0d got=%b exp=0", u, rd_valid[u]); end
    total++; if (rd_data[u] !== 16'h0000) begin bad++; $display("FAIL reset_rd_data u=%0d got=%h exp=0000", u, rd_data[u]); end
    total++; if (clear_busy[u] !== 1'b1) begin bad++; $display("FAIL reset_busy u=%0d got=%b exp=1", u, clear_busy[u]); end
    for (int j = 1; j <= clen_of(u); j++) begin
      step(u, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
      total++; if (clear_busy[u] !== (j < clen_of(u))) begin bad++; $display("FAIL clear_busy u=%0d cyc=%0d got=%b exp=%b", u, j, clear_busy[u], (j < clen_of(u))); end
      total++; if (req_ready[u] !== (j == clen_of(u))) begin bad++; $display("FAIL clear_ready u=%0d cyc=%0d got=%b exp=%b", u, j, req_ready[u], (j == clen_of(u))); end
    end
  endtask

  task automatic test_clear_zero(input int u);
    int l;
    logic ex;
    l = lat_of(u);
    for (int t = 0; t < 16 + l + 1; t++) begin
      if (t < 16) step(u, 1'b1, 1'b1, 1'b0, 16'(t), 16'h0, 2'b00);
      else        step(u, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
      ex = (t >= l - 1) && (t < l - 1 + 16);
      total++; if (rd_valid[u] !== ex) begin bad++; $display("FAIL clear_zero_valid u=%0d t=%0d got=%b exp=%b", u, t, rd_valid[u], ex); end
      if (ex) begin
        total++; if (rd_data[u] !== 16'h0000) begin bad++; $display("FAIL clear_zero_data u=%0d t=%0d got=%h exp=0000", u, t, rd_data[u]); end
      end
    end
  endtask

  task automatic test_byte_enable(input int u);
    int l;
    logic ex;
    l = lat_of(u);
    step(u, 1'b1, 1'b1, 1'b1, 16'h0003, 16'hBEEF, 2'b11);
    step(u, 1'b1, 1'b1, 1'b1, 16'h0003, 16'h1234, 2'b10);
    step(u, 1'b1, 1'b1, 1'b1, 16'h0004, 16'hFFFF, 2'b00);
    step(u, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0000, 2'b00);
    for (int j = 0; j <= l + 1; j++) begin
      if (j > 0) step(u, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
      ex = (j == l - 1);
      total++; if (rd_valid[u] !== ex) begin bad++; $display("FAIL be_valid u=%0d j=%0d got=%b exp=%b", u, j, rd_valid[u], ex); end
      total++; if (j >= l - 1 && rd_data[u] !== 16'h12EF) begin bad++; $display("FAIL be_data u=%0d j=%0d got=%h exp=12EF", u, j, rd_data[u]); end
    end
  endtask

  task automatic test_back_to_back(input int u);
    int l;
    logic ex;
    logic [15:0] want;
    l = lat_of(u);
    for (int i = 0; i < 4; i++) step(u, 1'b1, 1'b1, 1'b1, 16'(i), 16'hA000 + 16'(i), 2'b11);
    for (int t = 0; t < l + 5; t++) begin
      if (t < 4) step(u, 1'b1, 1'b1, 1'b0, 16'(t), 16'h0, 2'b00);
      else       step(u, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
      ex   = (t >= l - 1) && (t < l + 3);
      want = 16'hA000 + 16'(t - (l - 1));
      total++; if (rd_valid[u] !== ex) begin bad++; $display("FAIL b2b_valid u=%0d t=%0d got=%b exp=%b", u, t, rd_valid[u], ex); end
      if (ex) begin
        total++; if (rd_data[u] !== want) begin bad++; $display("FAIL b2b_data u=%0d t=%0d got=%h exp=%h", u, t, rd_data[u], want); end
      end
    end
  endtask

  task automatic test_alias(input int u);
    int l;
    l = lat_of(u);
    step(u, 1'b1, 1'b1, 1'b1, 16'h0012, 16'h5555, 2'b11);
    step(u, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00);
    for (int j = 1; j < l; j++) step(u, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    total++; if (rd_valid[u] !== 1'b1) begin bad++; $display("FAIL alias_valid u=%0d got=%b exp=1", u, rd_valid[u]); end
    total++; if (rd_data[u] !== 16'h5555) begin bad++; $display("FAIL alias_data u=%0d got=%h exp=5555", u, rd_data[u]); end
    step(u, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
  endtask

  task automatic test_preserve(input int u);
    logic [15:0] words [16];
    int l;
    logic ex;
    l = lat_of(u);
    for (int i = 0; i < 16; i++) begin
      words[i] = 16'($urandom);
      step(u, 1'b1, 1'b1, 1'b1, 16'(i), words[i], 2'b11);
    end
    step(u, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    total++; if (req_ready[u] !== 1'b0) begin bad++; $display("FAIL keep_ready_rst u=%0d got=%b exp=0", u, req_ready[u]); end
    step(u, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    total++; if (req_ready[u] !== 1'b1) begin bad++; $display("FAIL keep_ready_rel u=%0d got=%b exp=1", u, req_ready[u]); end
    for (int t = 0; t < 16 + l + 1; t++) begin
      if (t < 16) step(u, 1'b1, 1'b1, 1'b0, 16'(t), 16'h0, 2'b00);
      else        step(u, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
      ex = (t >= l - 1) && (t < l - 1 + 16);
      total++; if (rd_valid[u] !== ex) begin bad++; $display("FAIL keep_valid u=%0d t=%0d got=%b exp=%b", u, t, rd_valid[u], ex); end
      if (ex) begin
        total++; if (rd_data[u] !== words[t - (l - 1)]) begin bad++; $display("FAIL keep_data u=%0d t=%0d got=%h exp=%h", u, t, rd_data[u], words[t - (l - 1)]); end
      end
    end
  endtask

  task automatic test_clear_restart(input int u);
    int l;
    l = lat_of(u);
    step(u, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    for (int j = 0; j < 5; j++) begin
      step(u, 1'b1, 1'b1, 1'b1, 16'h0005, 16'hFFFF, 2'b11);
      total++; if (req_ready[u] !== 1'b0) begin bad++; $display("FAIL restart_ready u=%0d j=%0d got=%b exp=0", u, j, req_ready[u]); end
    end
    step(u, 1'b0, 1'b1, 1'b1, 16'h0005, 16'hFFFF, 2'b11);
    for (int j = 1; j <= 16; j++) begin
      step(u, 1'b1, 1'b1, 1'b1, 16'h0005, 16'hFFFF, 2'b11);
      total++; if (clear_busy[u] !== (j < 16)) begin bad++; $display("FAIL restart_busy u=%0d j=%0d got=%b exp=%b", u, j, clear_busy[u], (j < 16)); end
    end
    step(u, 1'b1, 1'b1, 1'b0, 16'h0005, 16'h0, 2'b00);
    for (int j = 1; j < l; j++) step(u, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    total++; if (rd_valid[u] !== 1'b1 || rd_data[u] !== 16'h0000) begin bad++; $display("FAIL restart_data u=%0d got=%b/%h exp=1/0000", u, rd_valid[u], rd_data[u]); end
  endtask

  task automatic test_reset_inflight(input int u);
    int l;
    int c;
    logic [15:0] want;
    l = lat_of(u);
    c = clen_of(u);
    step(u, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h0, 2'b00);
    step(u, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h0, 2'b00);
    total++; if (rd_valid[u] !== 1'b0 || clear_busy[u] !== 1'b1 || req_ready[u] !== 1'b0) begin
      bad++; $display("FAIL inflight_rst u=%0d got v=%b busy=%b rdy=%b exp 0/1/0", u, rd_valid[u], clear_busy[u], req_ready[u]);
    end
    for (int j = 1; j <= c + l; j++) begin
      step(u, 1'b1, (j <= c), 1'b1, 16'h0009, 16'h7777, 2'b11);
      total++; if (rd_valid[u] !== 1'b0) begin bad++; $display("FAIL inflight_valid u=%0d j=%0d got=%b exp=0", u, j, rd_valid[u]); end
      total++; if (clear_busy[u] !== (j < c)) begin bad++; $display("FAIL inflight_busy u=%0d j=%0d got=%b exp=%b", u, j, clear_busy[u], (j < c)); end
    end
    want = mdl[u][9];
    step(u, 1'b1, 1'b1, 1'b0, 16'h0009, 16'h0, 2'b00);
    for (int j = 1; j < l; j++) step(u, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    total++; if (rd_valid[u] !== 1'b1 || rd_data[u] !== want) begin bad++; $display("FAIL inflight_after u=%0d got=%b/%h exp=1/%h", u, rd_valid[u], rd_data[u], want); end
  endtask

  task automatic test_random(input int u, input int n);
    logic        v;
    logic        we;
    logic [15:0] a;
    logic [15:0] d;
    logic [1:0]  be;
    for (int e = 0; e < n + lat_of(u) + 1; e++) begin
      v  = (e < n) && ($urandom_range(0, 3) != 0);
      we = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      d  = 16'($urandom);
      be = 2'($urandom);
      total++; if (req_ready[u] !== 1'b1) begin bad++; $display("FAIL rnd_ready u=%0d e=%0d got=%b exp=1", u, e, req_ready[u]); end
      step(u, 1'b1, v, we, a, d, be);
      total++; if (rd_valid[u] !== ev[u][ecnt]) begin bad++; $display("FAIL rnd_valid u=%0d e=%0d got=%b exp=%b", u, e, rd_valid[u], ev[u][ecnt]); end
      total++; if (rd_data[u] !== last[u]) begin bad++; $display("FAIL rnd_data u=%0d e=%0d got=%h exp=%h", u, e, rd_data[u], last[u]); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ecnt  = 0;
    for (int k = 0; k < NU; k++) begin
      rst[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0; req_be[k] = '0;
      mready[k] = 1'b0; mclr[k] = 0; last[k] = 16'h0000;
      for (int t = 0; t < ECAP; t++) begin ev[k][t] = 1'b0; ed[k][t] = 16'h0000; end
    end
    @(negedge clk);
    for (int u = 0; u < NU; u++) test_reset(u);
    test_clear_zero(0);
    test_clear_zero(1);
    for (int u = 0; u < NU; u++) begin
      test_byte_enable(u);
      test_back_to_back(u);
      test_alias(u);
    end
    test_preserve(2);
    test_clear_restart(1);
    test_reset_inflight(1);
    test_reset_inflight(2);
    for (int u = 0; u < NU; u++) test_random(u, 250);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
